hazard3_div_iter: RTL and testbench
===================================

HAZARD3_DIV_ITER -- requirements
Module: hazard3_div_iter

Interface
REQ-001 SHALL have parameter W_DATA, default 32, giving the operand and result width.
REQ-002 SHALL have parameter W_MULOP, default 3, giving the width of the op code.
REQ-003 SHALL have input port clk, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have input port rst_n, width 1: reset, asynchronous and active-low.
REQ-005 SHALL have input port op, width W_MULOP: operation select. 4=DIV, 5=DIVU, 6=REM, 7=REMU. Only op[1:0] are decoded: op[1] selects remainder and op[0] selects unsigned.
REQ-006 SHALL have input port op_vld, width 1: operation request.
REQ-007 SHALL have input ports op_a, width W_DATA (dividend), and op_b, width W_DATA (divisor).
REQ-008 SHALL have input port op_kill, width 1: abort of the in-flight operation.
REQ-009 SHALL have output port op_rdy, width 1: block can accept an operation.
REQ-010 SHALL have output port result, width W_DATA: quotient or remainder.
REQ-011 SHALL have output port result_vld, width 1: one-cycle result strobe.

Function
REQ-012 SHALL accept an operation on a rising edge where op_vld && op_rdy, capturing op, |op_a| and |op_b|.
- The absolute values are used only for signed ops; unsigned ops capture the operands as-is.
- The operand signs are captured at the same edge.
REQ-013 SHALL implement three states.
- IDLE: op_rdy=1.
- RUN: W_DATA steps of radix-2 restoring division, one quotient bit per cycle, tracked by an iteration counter.
- FIX: sign correction and registration of the result.
REQ-014 SHALL use the following state transitions.
- IDLE->RUN on accept.
- RUN->FIX on the edge performing the last step (counter==0).
- FIX->IDLE unconditionally.
REQ-015 SHALL have a fixed latency: for an accept at edge E0, the steps occur at edges E1..E(W_DATA), FIX registers at edge E(W_DATA+1), and result_vld is high for exactly the following cycle.
- For W_DATA=32, result_vld is high in the 34th cycle after the op_vld cycle.
REQ-016 SHALL hold op_rdy low in RUN and FIX, and SHALL ignore op_vld there, so no operation is queued.
REQ-017 SHALL return to IDLE on the same edge that asserts result_vld, so a new accept is possible in the result_vld cycle (back-to-back throughput of W_DATA+2 cycles).
REQ-018 SHALL hold result stable from FIX until the next FIX completes.
- result is undefined only before the first completion after reset.
REQ-019 SHALL, for signed ops, negate the quotient iff the operand signs differ and op_b != 0, and SHALL give the remainder the sign of op_a.
REQ-020 SHALL, on divide by zero, return quotient = all ones and remainder = op_a, for both signed and unsigned ops.
REQ-021 SHALL, on signed overflow (op_a = most negative value, op_b = -1), return quotient = op_a and remainder = 0.
REQ-022 SHALL, on op_kill in RUN or FIX, go to IDLE on the next edge with no result_vld pulse and result left unchanged.
- op_kill in IDLE SHALL have no effect.
- op_kill coincident with accept SHALL block the accept.
REQ-023 SHALL, on the edge leaving FIX, drive result = quotient for DIV/DIVU and remainder for REM/REMU.

Reset
REQ-024 SHALL, while rst_n is low, force state=IDLE, counter=0, result_vld=0 and op_rdy=1.
- Datapath registers and result SHALL have no reset.
REQ-025 SHALL, on reset asserted mid-operation, discard the operation, and SHALL produce no result_vld after deassertion until a new accept.

Verification
REQ-026 SHALL cover: DIV 100/7 -> result 14; REM 100/7 -> result 2; result_vld exactly 34 cycles after the op_vld cycle, op_rdy low between.
REQ-027 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
REQ-028 SHALL cover: DIV 5/0 -> 0xFFFFFFFF; REMU 0x12345678/0 -> 0x12345678; DIV -5/0 -> 0xFFFFFFFF.
REQ-029 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-030 SHALL cover: op_kill pulsed 10 cycles after accept -> no result_vld, op_rdy=1 next cycle, previous result unchanged; a following DIVU 9/3 -> 3.
REQ-031 SHALL cover: back-to-back DIVU 9/3 then REMU 10/4, with the second accepted in the first's result_vld cycle -> results 3 then 2, 34 cycles apart.

Source files
------------

// File: rtl/hazard3_div_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, then a
// sign-fix cycle. Handles DIV/DIVU/REM/REMU including divide-by-zero and overflow.
module hazard3_div_iter #(
    parameter int W_DATA  = 32,
    parameter int W_MULOP = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W_MULOP-1:0] op,
    input  logic               op_vld,
    input  logic [W_DATA-1:0]  op_a,
    input  logic [W_DATA-1:0]  op_b,
    input  logic               op_kill,
    output logic               op_rdy,
    output logic [W_DATA-1:0]  result,
    output logic               result_vld
);

    localparam int W_CTR = $clog2(W_DATA);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [W_CTR-1:0]    r_ctr;
    logic                r_result_vld;
    logic [W_DATA-1:0]   r_result;

    logic [2*W_DATA-1:0] r_acc;    // {partial remainder, dividend/quotient}
    logic [W_DATA-1:0]   r_b;
    logic                r_op_rem;
    logic                r_sign_a;
    logic                r_sign_b;

    logic                w_accept;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [W_DATA-1:0]   w_a_abs;
    logic [W_DATA-1:0]   w_b_abs;
    logic [W_DATA:0]     w_rem_sh;
    logic [W_DATA:0]     w_diff;
    logic                w_ge;
    logic [2*W_DATA-1:0] w_acc_step;
    logic [W_DATA-1:0]   w_quot;
    logic [W_DATA-1:0]   w_rem;
    logic                w_neg_q;
    logic [W_DATA-1:0]   w_fixed;
    logic                w_unused_op;

    // Only op[1:0] carry meaning; upper bits are deliberately ignored.
    assign w_unused_op = &{1'b0, op[W_MULOP-1:2]};

    assign w_a_neg = ~op[0] & op_a[W_DATA-1];
    assign w_b_neg = ~op[0] & op_b[W_DATA-1];
    assign w_a_abs = w_a_neg ? (~op_a + 1'b1) : op_a;
    assign w_b_abs = w_b_neg ? (~op_b + 1'b1) : op_b;

    // Shifted remainder needs one extra bit so divisors above 2^(W-1) still work.
    assign w_rem_sh   = r_acc[2*W_DATA-1:W_DATA-1];
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_ge       = (w_rem_sh >= {1'b0, r_b});
    assign w_acc_step = w_ge ? {w_diff[W_DATA-1:0], r_acc[W_DATA-2:0], 1'b1}
                             : {r_acc[2*W_DATA-2:0], 1'b0};

    assign w_quot  = r_acc[W_DATA-1:0];
    assign w_rem   = r_acc[2*W_DATA-1:W_DATA];
    assign w_neg_q = (r_sign_a ^ r_sign_b) & (r_b != '0);
    assign w_fixed = r_op_rem ? (r_sign_a ? (~w_rem + 1'b1) : w_rem)
                              : (w_neg_q ? (~w_quot + 1'b1) : w_quot);

    always_comb begin
        w_state_next = r_state;
        op_rdy       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                op_rdy   = 1'b1;
                w_accept = op_vld & ~op_kill;
                if (w_accept) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (op_kill)            w_state_next = S_IDLE;
                else if (r_ctr == '0)   w_state_next = S_FIX;
            end
            S_FIX: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ctr        <= '0;
            r_result_vld <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_result_vld <= (r_state == S_FIX) & ~op_kill;
            if (w_accept)
                r_ctr <= W_CTR'(W_DATA - 1);
            else if (r_state == S_RUN)
                r_ctr <= r_ctr - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_acc    <= {{W_DATA{1'b0}}, w_a_abs};
            r_b      <= w_b_abs;
            r_op_rem <= op[1];
            r_sign_a <= w_a_neg;
            r_sign_b <= w_b_neg;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_step;
        end
        if (r_state == S_FIX && !op_kill)
            r_result <= w_fixed;
    end

    assign result     = r_result;
    assign result_vld = r_result_vld;

endmodule

// File: tb/tb_hazard3_div_iter.sv
// Directed-vector bench for hazard3_div_iter: results, latency, kill, reset and
// back-to-back issue.
module tb_hazard3_div_iter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  op;
    logic        op_vld;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_kill;
    logic        op_rdy;
    logic [31:0] result;
    logic        result_vld;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    hazard3_div_iter #(.W_DATA(32), .W_MULOP(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .op_vld     (op_vld),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_kill    (op_kill),
        .op_rdy     (op_rdy),
        .result     (result),
        .result_vld (result_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge with op_rdy high; returns at the negedge of the
    // result_vld cycle (lat = cycles after the op_vld cycle, -1 on timeout).
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output bit rdy_low);
        op = o; op_a = a; op_b = b; op_vld = 1'b1;
        lat = -1; res = 'x; rdy_low = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            op_vld = 1'b0;
            if (result_vld) begin
                lat = c;
                res = result;
                break;
            end
            if (op_rdy) rdy_low = 1'b0;
        end
    endtask

    // Waits n cycles and reports whether result_vld was ever seen.
    task automatic watch_quiet(input int n, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (result_vld) seen = 1'b1;
        end
    endtask

    vec_t        vecs[12];
    int          lat;
    logic [31:0] res;
    logic [31:0] prev;
    bit          rdy_low;
    bit          seen;

    initial begin
        vecs[0]  = '{"div_100_7",    DIV,  32'd100,        32'd7,          32'd14};
        vecs[1]  = '{"rem_100_7",    REM,  32'd100,        32'd7,          32'd2};
        vecs[2]  = '{"div_m7_2",     DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD};
        vecs[3]  = '{"rem_m7_2",     REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF};
        vecs[4]  = '{"divu_big_2",   DIVU, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC};
        vecs[5]  = '{"div_5_0",      DIV,  32'd5,          32'd0,          32'hFFFFFFFF};
        vecs[6]  = '{"remu_x_0",     REMU, 32'h12345678,   32'd0,          32'h12345678};
        vecs[7]  = '{"div_m5_0",     DIV,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF};
        vecs[8]  = '{"div_ovf",      DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000};
        vecs[9]  = '{"rem_ovf",      REM,  32'h80000000,   32'hFFFFFFFF,   32'h00000000};
        vecs[10] = '{"rem_m5_0",     REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB};
        vecs[11] = '{"divu_bigdiv",  DIVU, 32'hF0000000,   32'h90000000,   32'd1};

        rst_n = 1'b0; op = 3'd0; op_vld = 1'b0; op_a = '0; op_b = '0; op_kill = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_op_rdy", {31'd0, op_rdy}, 32'd1);
        check("reset_result_vld", {31'd0, result_vld}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, rdy_low);
            $display("op=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d", vecs[i].op,
                     vecs[i].a, vecs[i].b, res, lat);
            check({vecs[i].name, "_result"}, res, vecs[i].exp);
            check({vecs[i].name, "_latency"}, lat, 34);
            check({vecs[i].name, "_rdy_low"}, {31'd0, rdy_low}, 32'd1);
            @(negedge clk);
        end
        prev = 32'd1;  // last vector's result

        // Kill 10 cycles after accept.
        op = DIVU; op_a = 32'd1000; op_b = 32'd10; op_vld = 1'b1;
        @(negedge clk);
        op_vld = 1'b0;
        repeat (9) @(negedge clk);
        op_kill = 1'b1;
        @(negedge clk);
        op_kill = 1'b0;
        check("kill_rdy_next", {31'd0, op_rdy}, 32'd1);
        check("kill_result_kept", result, prev);
        watch_quiet(40, seen);
        check("kill_no_vld", {31'd0, seen}, 32'd0);
        $display("kill: op_rdy=%0d result=0x%08h vld_seen=%0d", op_rdy, result, seen);
        do_op(DIVU, 32'd9, 32'd3, lat, res, rdy_low);
        check("after_kill_divu_9_3", res, 32'd3);
        check("after_kill_latency", lat, 34);
        @(negedge clk);

        // Kill coincident with op_vld blocks the accept.
        op = DIVU; op_a = 32'd50; op_b = 32'd5; op_vld = 1'b1; op_kill = 1'b1;
        @(negedge clk);
        op_vld = 1'b0; op_kill = 1'b0;
        check("kill_accept_rdy", {31'd0, op_rdy}, 32'd1);
        watch_quiet(40, seen);
        check("kill_accept_no_vld", {31'd0, seen}, 32'd0);
        $display("kill+accept: vld_seen=%0d", seen);

        // Reset mid-operation discards it.
        op = DIVU; op_a = 32'd50; op_b = 32'd5; op_vld = 1'b1;
        @(negedge clk);
        op_vld = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rdy", {31'd0, op_rdy}, 32'd1);
        rst_n = 1'b1;
        watch_quiet(40, seen);
        check("midrst_no_vld", {31'd0, seen}, 32'd0);
        $display("reset mid-op: vld_seen=%0d", seen);

        // Back-to-back: second issue in the first's result_vld cycle.
        do_op(DIVU, 32'd9, 32'd3, lat, res, rdy_low);
        check("b2b_first", res, 32'd3);
        check("b2b_first_lat", lat, 34);
        check("b2b_rdy_in_vld", {31'd0, op_rdy}, 32'd1);
        do_op(REMU, 32'd10, 32'd4, lat, res, rdy_low);
        check("b2b_second", res, 32'd2);
        check("b2b_second_lat", lat, 34);
        $display("back-to-back: second result=0x%08h latency=%0d", res, lat);
        @(negedge clk);
        check("b2b_vld_one_cycle", {31'd0, result_vld}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
